// File: rtl/onehot_dispatch_decoder.sv
// ---------------------------------------------------------------------------
// onehot_dispatch_decoder
//
// Takes an encoded target index over a valid/ready handshake and turns it
// into a registered one-hot grant. The grant is held until the selected
// target acknowledges or the grant has been held for TIMEOUT cycles.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   in_valid      encoded index valid
//   in_ready      block can accept an index (IDLE and not in reset)
//   in_idx        encoded target index
//   ack           per-target acknowledge (only the granted bit matters)
//   grant         registered one-hot grant
//   grant_idx     index of current/last grant
//   busy          high while a grant is active
//   done_pulse    one-cycle pulse: grant completed by ack
//   timeout_pulse one-cycle pulse: grant aborted by timeout
//   err_pulse     one-cycle pulse: accepted index >= N_OUT
// ---------------------------------------------------------------------------
module onehot_dispatch_decoder #(
    parameter int N_OUT   = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [N_OUT-1:0] ack,
    output logic [N_OUT-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             done_pulse,
    output logic             timeout_pulse,
    output logic             err_pulse
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Last timer value before the grant is abandoned.
    localparam logic [7:0]     TIMER_LAST = 8'(TIMEOUT - 1);
    // N_OUT widened by one bit so the range check also works when N_OUT == 2**IDX_W.
    localparam logic [IDX_W:0] N_OUT_LIM  = (IDX_W + 1)'(N_OUT);

    state_t           state_r;
    logic [7:0]       timer_r;
    logic             idx_ok_s;
    logic             ack_hit_s;
    logic [N_OUT-1:0] dec_s;

    // in_ready depends on state only, forced low while reset is held.
    assign in_ready  = (state_r == IDLE) && !rst;

    assign idx_ok_s  = ({1'b0, in_idx} < N_OUT_LIM);

    // grant is one-hot at grant_idx while ACTIVE, so masking ack with grant
    // selects ack[grant_idx] without an out-of-range variable index.
    assign ack_hit_s = |(ack & grant);

    // Binary-to-one-hot decode of the incoming index.
    always_comb begin
        dec_s = {N_OUT{1'b0}};
        for (int i = 0; i < N_OUT; i++) begin
            if (in_idx == IDX_W'(i)) begin
                dec_s[i] = 1'b1;
            end else begin
                dec_s[i] = 1'b0;
            end
        end
    end

    // Handshake / grant state machine with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            timer_r       <= 8'd0;
            grant         <= {N_OUT{1'b0}};
            grant_idx     <= {IDX_W{1'b0}};
            busy          <= 1'b0;
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
            err_pulse     <= 1'b0;
        end else begin
            done_pulse    <= 1'b0;
            timeout_pulse <= 1'b0;
            err_pulse     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (idx_ok_s) begin
                            state_r   <= ACTIVE;
                            grant     <= dec_s;
                            grant_idx <= in_idx;
                            busy      <= 1'b1;
                            timer_r   <= 8'd0;
                        end else begin
                            // Out-of-range index is consumed but leaves grant state untouched.
                            err_pulse <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    // Ack wins over a coincident timeout.
                    if (ack_hit_s) begin
                        state_r    <= IDLE;
                        grant      <= {N_OUT{1'b0}};
                        busy       <= 1'b0;
                        done_pulse <= 1'b1;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r       <= IDLE;
                        grant         <= {N_OUT{1'b0}};
                        busy          <= 1'b0;
                        timeout_pulse <= 1'b1;
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    grant   <= {N_OUT{1'b0}};
                    busy    <= 1'b0;
                    timer_r <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_dispatch_decoder.sv
// Bench for onehot_dispatch_decoder: a table of transactions on an N_OUT=4
// instance checked through a scoreboard queue, plus hand-written sequences
// (held in_valid, reset mid-grant, N_OUT=3 out-of-range index).
module tb_onehot_dispatch_decoder;

    localparam logic [1:0] K_DONE = 2'b01;   // {timeout_pulse, done_pulse}
    localparam logic [1:0] K_TMO  = 2'b10;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] wrong;      // ack pattern driven on non-matching cycles
        int         ack_cycle;  // grant cycle carrying the matching ack, 0 = never
        logic [1:0] kind;
        logic [3:0] grant;
        int         len;        // expected number of grant cycles
    } vec_t;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] grant;
        logic [1:0] idx;
        int         len;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // N_OUT = 4 instance
    logic       in_valid, in_ready, busy, done_pulse, timeout_pulse, err_pulse;
    logic [1:0] in_idx, grant_idx;
    logic [3:0] ack, grant;

    // N_OUT = 3 instance
    logic       v3, r3, b3, d3, t3, e3;
    logic [1:0] i3, gi3;
    logic [2:0] a3, g3;

    onehot_dispatch_decoder #(.N_OUT(4), .IDX_W(2), .TIMEOUT(15)) u4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .ack(ack), .grant(grant), .grant_idx(grant_idx),
        .busy(busy), .done_pulse(done_pulse), .timeout_pulse(timeout_pulse),
        .err_pulse(err_pulse)
    );

    onehot_dispatch_decoder #(.N_OUT(3), .IDX_W(2), .TIMEOUT(15)) u3 (
        .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3),
        .in_idx(i3), .ack(a3), .grant(g3), .grant_idx(gi3),
        .busy(b3), .done_pulse(d3), .timeout_pulse(t3), .err_pulse(e3)
    );

    int   tests = 0;
    int   fails = 0;
    int   pops = 0;
    int   pushes = 0;
    exp_t sb[$];
    vec_t vecs[6];

    logic [3:0] run_grant = 4'd0;
    logic [3:0] prev_grant = 4'd0;
    int         run_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle observation of the N_OUT=4 instance; pops the scoreboard on each pulse.
    task automatic mon_step();
        exp_t e;
        chk("ready_vs_busy", 32'(in_ready), 32'(!busy && !rst));
        chk("grant_shape", 32'(busy ? $onehot(grant) : (grant == 4'd0)), 32'd1);
        chk("pulse_excl", 32'(done_pulse && timeout_pulse), 32'd0);
        chk("no_err4", 32'(err_pulse), 32'd0);
        if (rst) begin
            chk("rst_pulses", 32'({timeout_pulse, done_pulse}), 32'd0);
            prev_grant = 4'd0;
            run_len    = 0;
        end else begin
            if (grant != 4'd0) begin
                if (prev_grant == 4'd0) begin
                    run_grant = grant;
                    run_len   = 1;
                end else begin
                    chk("grant_stable", 32'(grant), 32'(run_grant));
                    run_len++;
                end
            end
            if (done_pulse || timeout_pulse) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 32'({timeout_pulse, done_pulse}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    chk("outcome", 32'({timeout_pulse, done_pulse}), 32'(e.kind));
                    chk("grant_val", 32'(run_grant), 32'(e.grant));
                    chk("grant_len", 32'(run_len), 32'(e.len));
                    chk("grant_idx", 32'(grant_idx), 32'(e.idx));
                    chk("grant_off", 32'(grant), 32'd0);
                end
            end
            prev_grant = grant;
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] kind, input logic [3:0] g,
                            input logic [1:0] idx, input int len);
        exp_t e;
        e.kind  = kind;
        e.grant = g;
        e.idx   = idx;
        e.len   = len;
        sb.push_back(e);
        pushes++;
    endtask

    task automatic do_txn(input vec_t v);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_idx   = v.idx;
        push_exp(v.kind, v.grant, v.idx, v.len);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= v.len; c++) begin
            ack = (c == v.ack_cycle) ? v.grant : v.wrong;
            if (c == 1) chk("grant_idx_live", 32'(grant_idx), 32'(v.idx));
            tick();
        end
        // Pulse cycle is IDLE: an all-ones ack here must be ignored.
        chk("ready_at_pulse", 32'(in_ready), 32'd1);
        ack = 4'b1111;
        tick();
        ack = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{2'd2, 4'b0000, 3,  K_DONE, 4'b0100, 3};
        vecs[1] = '{2'd0, 4'b0000, 0,  K_TMO,  4'b0001, 15};
        vecs[2] = '{2'd3, 4'b0111, 6,  K_DONE, 4'b1000, 6};
        vecs[3] = '{2'd1, 4'b0000, 15, K_DONE, 4'b0010, 15};
        vecs[4] = '{2'd1, 4'b1101, 1,  K_DONE, 4'b0010, 1};
        vecs[5] = '{2'd3, 4'b0111, 0,  K_TMO,  4'b1000, 15};

        rst = 1'b1; in_valid = 1'b0; in_idx = 2'd0; ack = 4'd0;
        v3 = 1'b0; i3 = 2'd0; a3 = 3'd0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_pulses_all", 32'({done_pulse, timeout_pulse, err_pulse}), 32'd0);
        chk("rst_ready3", 32'(r3), 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Held in_valid: index 1 then 2 with no drop or duplicate.
        push_exp(K_DONE, 4'b0010, 2'd1, 2);
        push_exp(K_DONE, 4'b0100, 2'd2, 3);
        in_valid = 1'b1; in_idx = 2'd1;
        tick();
        in_idx = 2'd2;
        chk("held_ready_low", 32'(in_ready), 32'd0);
        tick();
        ack = 4'b0010;
        tick();
        ack = 4'b0000;
        chk("held_gap", 32'(grant), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("held_second", 32'(grant), 32'h4);
        tick();
        tick();
        ack = 4'b0100;
        tick();
        ack = 4'b0000;
        repeat (3) tick();

        // Reset in the middle of a grant: drops at once, no pulse afterwards.
        in_valid = 1'b1; in_idx = 2'd1;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_grant", 32'(grant), 32'h2);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(in_ready), 32'd1);
        repeat (20) tick();

        // N_OUT=3: valid grant, then out-of-range index.
        v3 = 1'b1; i3 = 2'd2;
        tick();
        v3 = 1'b0;
        chk("n3_grant", 32'(g3), 32'h4);
        chk("n3_idx", 32'(gi3), 32'd2);
        a3 = 3'b100;
        tick();
        a3 = 3'b000;
        chk("n3_done", 32'(d3), 32'd1);
        chk("n3_off", 32'(g3), 32'd0);
        v3 = 1'b1; i3 = 2'd3;
        tick();
        v3 = 1'b0;
        chk("n3_err", 32'(e3), 32'd1);
        chk("n3_err_grant", 32'(g3), 32'd0);
        chk("n3_err_idx", 32'(gi3), 32'd2);
        chk("n3_err_idle", 32'({r3, b3}), 32'h2);
        chk("n3_err_excl", 32'({d3, t3}), 32'd0);
        tick();
        chk("n3_err_once", 32'(e3), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("sb_pops", 32'(pops), 32'(pushes));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
